zx_vga_timing: RTL and testbench

Raster timing generator for the ZX Spectrum video path: produces the 640x480@60 VGA scan (800x525 total) from the 25.175 MHz pixel clock. It drives the ULA video stage with pixel coordinates `x`/`y` whose origin is the top-left of the 512x384 paper area, plus `de` and the paper-window flag `screen`. It also produces `hs`/`vs`, which are delayed to line up with the ULA's registered colour output, and a once-per-frame pulse.

---
 rtl/zx_vga_pkg.sv | 45 ++++
 rtl/zx_vga_timing_sync_delay.sv | 46 ++++
 rtl/zx_vga_timing.sv | 151 +++++++++++++++
 tb/tb_zx_vga_timing.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zx_vga_pkg
//  Description : Shared constants for the ZX Spectrum VGA raster generator.
//                Holds the default 640x480@60 timing, the derived line and
//                frame totals, the sync window bounds and the coordinate
//                width used by the ULA video stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package zx_vga_pkg;

   // Default horizontal timing (pixel clocks)
   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC     = 96;
   localparam int DEF_H_BP       = 48;

   // Default vertical timing (lines)
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC     = 2;
   localparam int DEF_V_BP       = 33;

   // Paper window: 256x192 Spectrum pixels, each doubled in both axes
   localparam int DEF_PAPER_X0   = 64;
   localparam int DEF_PAPER_Y0   = 48;
   localparam int DEF_PAPER_W    = 512;
   localparam int DEF_PAPER_H    = 384;

   // Extra clocks on hs/vs to match the ULA's registered colour output
   localparam int DEF_SYNC_DELAY = 1;

   // Derived totals and sync windows for the default timing
   localparam int H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
   localparam int V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

   // Width of the paper-relative x/y coordinates (wrap mod 2048)
   localparam int COORD_W      = 11;

endpackage : zx_vga_pkg
`default_nettype wire

// File: rtl/zx_vga_timing_sync_delay.sv
`default_nettype none
// ============================================================================
//  Module      : sync_delay
//  Description : N-stage shift register for a single active-low sync line.
//                Every stage resets to 1 so the line reads inactive until
//                real sync data has propagated through. With N=0 the input
//                passes straight through.
//  Ports       : clk      - pixel clock
//                reset_n  - asynchronous reset, active low
//                d_i      - undelayed sync level
//                q_o      - sync level delayed by N clocks
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_delay #(
   parameter int N = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_i,
   output logic q_o
);

   if (N == 0) begin : g_wire
      // Clock and reset are not needed when there are no stages.
      logic w_unused;
      assign w_unused = clk ^ reset_n;
      assign q_o      = d_i;
   end else begin : g_shift
      logic [N-1:0] sr_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sr_q <= '1;
         end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
               sr_q[i] <= sr_q[i-1];
            end
         end
      end

      assign q_o = sr_q[N-1];
   end

endmodule : sync_delay
`default_nettype wire

// File: rtl/zx_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : zx_vga_timing
//  Description : Raster timing generator for the ZX Spectrum VGA path.
//                Free-running hc/vc counters scan the 800x525 frame; the
//                decode is registered so every output is one clock behind
//                the counters. hs/vs get SYNC_DELAY further clocks so they
//                line up with the ULA's registered colour output.
//  Ports       : clk         - pixel clock (25.175 MHz)
//                reset_n     - asynchronous reset, active low
//                x, y        - counters minus paper origin, mod 2048
//                de          - inside the visible area
//                screen      - inside the paper window
//                hs, vs      - syncs, active low
//                frame_start - one-clock pulse on the first pixel of a frame
//  Revision    : 1.0 - initial release
// ============================================================================
module zx_vga_timing
   import zx_vga_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int PAPER_X0   = DEF_PAPER_X0,
   parameter int PAPER_Y0   = DEF_PAPER_Y0,
   parameter int PAPER_W    = DEF_PAPER_W,
   parameter int PAPER_H    = DEF_PAPER_H,
   parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               de,
   output logic               screen,
   output logic               hs,
   output logic               vs,
   output logic               frame_start
);

   localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_hc_w    = $clog2(c_h_total);
   localparam int c_vc_w    = $clog2(c_v_total);

   localparam logic [c_hc_w-1:0] c_h_last     = c_hc_w'(c_h_total - 1);
   localparam logic [c_vc_w-1:0] c_v_last     = c_vc_w'(c_v_total - 1);
   localparam logic [c_hc_w-1:0] c_h_active   = c_hc_w'(H_ACTIVE);
   localparam logic [c_vc_w-1:0] c_v_active   = c_vc_w'(V_ACTIVE);
   localparam logic [c_hc_w-1:0] c_hs_start   = c_hc_w'(H_ACTIVE + H_FP);
   localparam logic [c_hc_w-1:0] c_hs_end     = c_hc_w'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [c_vc_w-1:0] c_vs_start   = c_vc_w'(V_ACTIVE + V_FP);
   localparam logic [c_vc_w-1:0] c_vs_end     = c_vc_w'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [c_hc_w-1:0] c_px_start   = c_hc_w'(PAPER_X0);
   localparam logic [c_hc_w-1:0] c_px_end     = c_hc_w'(PAPER_X0 + PAPER_W);
   localparam logic [c_vc_w-1:0] c_py_start   = c_vc_w'(PAPER_Y0);
   localparam logic [c_vc_w-1:0] c_py_end     = c_vc_w'(PAPER_Y0 + PAPER_H);
   localparam logic [COORD_W-1:0] c_px0       = COORD_W'(PAPER_X0);
   localparam logic [COORD_W-1:0] c_py0       = COORD_W'(PAPER_Y0);
   // Reset coordinates are the decode of hc=0/vc=0 (e.g. 1984/2000)
   localparam logic [COORD_W-1:0] c_x_rst     = COORD_W'(0 - PAPER_X0);
   localparam logic [COORD_W-1:0] c_y_rst     = COORD_W'(0 - PAPER_Y0);

   // Counters
   logic [c_hc_w-1:0]  hc_q, hc_d;
   logic [c_vc_w-1:0]  vc_q, vc_d;

   // Registered decode
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               de_q, de_d;
   logic               screen_q, screen_d;
   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic               fs_q, fs_d;

   always_comb begin
      hc_d = hc_q + c_hc_w'(1);
      vc_d = vc_q;
      if (hc_q == c_h_last) begin
         hc_d = '0;
         // vc only moves on the hc wrap, and wraps on that same clock
         vc_d = (vc_q == c_v_last) ? '0 : vc_q + c_vc_w'(1);
      end

      de_d     = (hc_q < c_h_active) && (vc_q < c_v_active);
      // Paper lies wholly inside the visible area, but gating with de
      // keeps screen a strict subset even for odd parameter choices.
      screen_d = de_d
                 && (hc_q >= c_px_start) && (hc_q < c_px_end)
                 && (vc_q >= c_py_start) && (vc_q < c_py_end);
      hs_d     = !((hc_q >= c_hs_start) && (hc_q < c_hs_end));
      vs_d     = !((vc_q >= c_vs_start) && (vc_q < c_vs_end));
      fs_d     = (hc_q == '0) && (vc_q == '0);

      // 11-bit wrap gives paper at 0.. and border at the top of the range
      x_d      = COORD_W'(hc_q) - c_px0;
      y_d      = COORD_W'(vc_q) - c_py0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hc_q     <= '0;
         vc_q     <= '0;
         x_q      <= c_x_rst;
         y_q      <= c_y_rst;
         de_q     <= 1'b0;
         screen_q <= 1'b0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         fs_q     <= 1'b0;
      end else begin
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         x_q      <= x_d;
         y_q      <= y_d;
         de_q     <= de_d;
         screen_q <= screen_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         fs_q     <= fs_d;
      end
   end

   sync_delay #(.N(SYNC_DELAY)) u_hs_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (hs_q),
      .q_o     (hs)
   );

   sync_delay #(.N(SYNC_DELAY)) u_vs_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     (vs_q),
      .q_o     (vs)
   );

   assign x           = x_q;
   assign y           = y_q;
   assign de          = de_q;
   assign screen      = screen_q;
   assign frame_start = fs_q;

endmodule : zx_vga_timing
`default_nettype wire

// File: tb/tb_zx_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zx_vga_timing
//  Description : Self-checking bench for zx_vga_timing. One instance uses
//                the full 800x525 timing; two use a tiny 24x19 raster
//                (SYNC_DELAY 3 and 0) so whole frames fit in a short run.
//                Expected outputs come from a cycle-index model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zx_vga_timing;

   typedef struct packed {
      logic [10:0] x;
      logic [10:0] y;
      logic        de;
      logic        screen;
      logic        hs;
      logic        vs;
      logic        fs;
   } out_t;

   typedef struct {
      int hact, hfp, hsync, hbp;
      int vact, vfp, vsync, vbp;
      int px0, py0, pw, ph, sd;
   } tm_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] xs [3];
   logic [10:0] ys [3];
   logic        des [3];
   logic        scrs [3];
   logic        hss [3];
   logic        vss [3];
   logic        fss [3];
   out_t        obs [3];

   always #5 clk = ~clk;

   zx_vga_timing #(.SYNC_DELAY(1)) u_dut (
      .clk(clk), .reset_n(reset_n), .x(xs[0]), .y(ys[0]), .de(des[0]),
      .screen(scrs[0]), .hs(hss[0]), .vs(vss[0]), .frame_start(fss[0])
   );

   zx_vga_timing #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .PAPER_X0(4), .PAPER_Y0(3), .PAPER_W(8), .PAPER_H(6), .SYNC_DELAY(3)
   ) u_small3 (
      .clk(clk), .reset_n(reset_n), .x(xs[1]), .y(ys[1]), .de(des[1]),
      .screen(scrs[1]), .hs(hss[1]), .vs(vss[1]), .frame_start(fss[1])
   );

   zx_vga_timing #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .PAPER_X0(4), .PAPER_Y0(3), .PAPER_W(8), .PAPER_H(6), .SYNC_DELAY(0)
   ) u_small0 (
      .clk(clk), .reset_n(reset_n), .x(xs[2]), .y(ys[2]), .de(des[2]),
      .screen(scrs[2]), .hs(hss[2]), .vs(vss[2]), .frame_start(fss[2])
   );

   for (genvar g = 0; g < 3; g++) begin : g_obs
      assign obs[g] = {xs[g], ys[g], des[g], scrs[g], hss[g], vss[g], fss[g]};
   end

   tm_t    tm [3];
   out_t   exp_q [$];
   longint k;
   int     n_chk, n_pass, n_fail;

   // Per-instance measurements
   int     de_cnt [3], scr_cnt [3], hs_cnt [3], vs_cnt [3], fs_cnt [3];
   longint fs_last [3], hsf_k [3], vsf_k [3], lo [3], hi [3];
   int     hsf_x [3], sr_x [3], sr_y [3], sf_x [3];
   bit     sr_seen [3], sf_seen [3];
   out_t   prev [3];

   function automatic longint htot(tm_t t);
      return longint'(t.hact + t.hfp + t.hsync + t.hbp);
   endfunction

   function automatic longint vtot(tm_t t);
      return longint'(t.vact + t.vfp + t.vsync + t.vbp);
   endfunction

   // Expected outputs after the kk-th rising edge since reset release
   // (kk=0: reset values). Derived from the absolute cycle index.
   function automatic out_t model(longint kk, tm_t t);
      out_t   o;
      longint ht, vt, c, c2, hc, vc;
      ht       = htot(t);
      vt       = vtot(t);
      o.x      = 11'((2048 - t.px0) % 2048);
      o.y      = 11'((2048 - t.py0) % 2048);
      o.de     = 1'b0;
      o.screen = 1'b0;
      o.hs     = 1'b1;
      o.vs     = 1'b1;
      o.fs     = 1'b0;
      if (kk > 0) begin
         c        = kk - 1;
         hc       = c % ht;
         vc       = (c / ht) % vt;
         o.x      = 11'((hc - t.px0 + 2048) % 2048);
         o.y      = 11'((vc - t.py0 + 2048) % 2048);
         o.de     = (hc < t.hact) && (vc < t.vact);
         o.screen = (hc >= t.px0) && (hc < t.px0 + t.pw) &&
                    (vc >= t.py0) && (vc < t.py0 + t.ph);
         o.fs     = (hc == 0) && (vc == 0);
         c2       = c - t.sd;
         if (c2 >= 0) begin
            hc   = c2 % ht;
            vc   = (c2 / ht) % vt;
            o.hs = !((hc >= t.hact + t.hfp) && (hc < t.hact + t.hfp + t.hsync));
            o.vs = !((vc >= t.vact + t.vfp) && (vc < t.vact + t.vfp + t.vsync));
         end
      end
      return o;
   endfunction

   task automatic chk(input string tag, input longint obs_v, input longint exp_v);
      n_chk++;
      assert (obs_v === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
      end
   endtask

   task automatic clear_metrics();
      for (int i = 0; i < 3; i++) begin
         de_cnt[i]  = 0; scr_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0;
         fs_cnt[i]  = 0; fs_last[i] = 0; hsf_k[i]  = 0; vsf_k[i]  = 0;
         hsf_x[i]   = 0; sr_x[i]    = 0; sr_y[i]   = 0; sf_x[i]   = 0;
         sr_seen[i] = 1'b0; sf_seen[i] = 1'b0;
      end
   endtask

   task automatic track(input int i);
      out_t cur;
      cur = obs[i];
      if (k >= lo[i] && k < hi[i]) begin
         de_cnt[i]  += int'(cur.de);
         scr_cnt[i] += int'(cur.screen);
         hs_cnt[i]  += int'(!cur.hs);
         vs_cnt[i]  += int'(!cur.vs);
      end
      if (prev[i].hs && !cur.hs && hsf_k[i] == 0) begin
         hsf_k[i] = k;
         hsf_x[i] = int'(cur.x);
      end
      if (prev[i].vs && !cur.vs && vsf_k[i] == 0) vsf_k[i] = k;
      if (!prev[i].screen && cur.screen && !sr_seen[i]) begin
         sr_seen[i] = 1'b1;
         sr_x[i]    = int'(cur.x);
         sr_y[i]    = int'(cur.y);
      end
      if (prev[i].screen && !cur.screen && !sf_seen[i]) begin
         sf_seen[i] = 1'b1;
         sf_x[i]    = int'(cur.x);
      end
      if (cur.fs) begin
         fs_cnt[i]++;
         if (fs_last[i] != 0) begin
            chk($sformatf("fs_period%0d", i), k - fs_last[i], htot(tm[i]) * vtot(tm[i]));
            chk($sformatf("y_wrap%0d", i), longint'(cur.y), (2048 - tm[i].py0) % 2048);
            chk($sformatf("y_last%0d", i), longint'(prev[i].y), vtot(tm[i]) - 1 - tm[i].py0);
         end
         fs_last[i] = k;
      end
   endtask

   // One clock: push expectations for this edge, then sample and compare.
   task automatic step();
      out_t e;
      @(posedge clk);
      if (!reset_n) k = 0;
      else          k++;
      for (int i = 0; i < 3; i++) exp_q.push_back(model(k, tm[i]));
      #1;
      for (int i = 0; i < 3; i++) begin
         e = exp_q.pop_front();
         chk($sformatf("sb%0d_k%0d", i, k), longint'(obs[i]), longint'(e));
         if (k > 0) track(i);
         prev[i] = obs[i];
      end
   endtask

   initial begin
      int exp_de [3], exp_scr [3], exp_hs [3], exp_vs [3];
      int exp_hsf_k [3], exp_hsf_x [3], exp_sf_x [3], exp_fs [3];
      int n;

      tm[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 64, 48, 512, 384, 1};
      tm[1] = '{16, 2, 4, 2, 12, 2, 2, 3, 4, 3, 8, 6, 3};
      tm[2] = '{16, 2, 4, 2, 12, 2, 2, 3, 4, 3, 8, 6, 0};

      // Windows start one line in, so early reset-held sync stages are excluded:
      // 49 whole lines for the full raster, one whole frame for the small ones.
      exp_de    = '{31360, 192, 192};
      exp_scr   = '{1024, 48, 48};
      exp_hs    = '{4704, 76, 76};
      exp_vs    = '{0, 48, 48};
      exp_hsf_k = '{658, 22, 19};
      exp_hsf_x = '{593, 17, 14};
      exp_sf_x  = '{512, 8, 8};
      exp_fs    = '{1, 88, 88};
      for (int i = 0; i < 3; i++) begin
         lo[i] = htot(tm[i]) + 1;
         hi[i] = lo[i] + ((i == 0) ? 39200 : 456);
      end

      n_chk = 0; n_pass = 0; n_fail = 0; k = 0;
      reset_n = 1'b0;
      clear_metrics();

      // Reset held for 5 clocks
      repeat (5) step();
      chk("rst_x",      longint'(obs[0].x),      1984);
      chk("rst_y",      longint'(obs[0].y),      2000);
      chk("rst_de",     longint'(obs[0].de),     0);
      chk("rst_screen", longint'(obs[0].screen), 0);
      chk("rst_hs",     longint'(obs[0].hs),     1);
      chk("rst_vs",     longint'(obs[0].vs),     1);
      chk("rst_fs",     longint'(obs[0].fs),     0);

      // First edge after release shows the hc=0/vc=0 decode
      @(negedge clk) reset_n = 1'b1;
      step();
      chk("first_fs",     longint'(obs[0].fs),     1);
      chk("first_x",      longint'(obs[0].x),      1984);
      chk("first_y",      longint'(obs[0].y),      2000);
      chk("first_de",     longint'(obs[0].de),     1);
      chk("first_screen", longint'(obs[0].screen), 0);

      repeat (39999) step();

      for (int i = 0; i < 3; i++) begin
         chk($sformatf("de_cnt%0d", i),  de_cnt[i],  exp_de[i]);
         chk($sformatf("scr_cnt%0d", i), scr_cnt[i], exp_scr[i]);
         chk($sformatf("hs_cnt%0d", i),  hs_cnt[i],  exp_hs[i]);
         chk($sformatf("vs_cnt%0d", i),  vs_cnt[i],  exp_vs[i]);
         chk($sformatf("hs_fall_k%0d", i), hsf_k[i], exp_hsf_k[i]);
         chk($sformatf("hs_fall_x%0d", i), hsf_x[i], exp_hsf_x[i]);
         chk($sformatf("scr_rise_seen%0d", i), longint'(sr_seen[i]), 1);
         chk($sformatf("scr_rise_x%0d", i), sr_x[i], 0);
         chk($sformatf("scr_rise_y%0d", i), sr_y[i], 0);
         chk($sformatf("scr_fall_x%0d", i), sf_x[i], exp_sf_x[i]);
         chk($sformatf("fs_cnt%0d", i), fs_cnt[i], exp_fs[i]);
      end
      // vs depends only on vc: falls at vc=V_SYNC_START, hc=0, plus 1+SYNC_DELAY
      chk("vs_fall_k1", vsf_k[1], 14 * 24 + 1 + 3);
      chk("vs_fall_k2", vsf_k[2], 14 * 24 + 1 + 0);

      // Mid-frame reset while the small raster is in vertical sync
      n = 0;
      while (obs[1].vs !== 1'b0 && n < 600) begin
         step();
         n++;
      end
      chk("vs_low_reached", longint'(obs[1].vs), 0);
      #2 reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++)
         chk($sformatf("rst_async%0d", i), longint'(obs[i]), longint'(model(0, tm[i])));
      repeat (3) step();
      @(negedge clk) reset_n = 1'b1;
      clear_metrics();
      repeat (1000) step();

      chk("re_vs_fall_k1", vsf_k[1], 14 * 24 + 1 + 3);
      chk("re_vs_fall_k2", vsf_k[2], 14 * 24 + 1 + 0);
      chk("re_hs_fall_k0", hsf_k[0], 656 + 1 + 1);
      chk("re_fs_cnt1",    fs_cnt[1], 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_zx_vga_timing
`default_nettype wire
